// File: rtl/mux_n_to_1_pipe.sv
// mux_n_to_1_pipe: N-to-1 word multiplexer feeding an elastic register pipeline.
//
// Selects word `sel` from the packed bus `in_w`. An out-of-range select yields
// a zero word with err=1. The result is tagged with its select index and
// registered through PIPE_DEPTH valid/ready stages. Ready ripples backward
// combinationally. Valid and data are registered only, so nothing passes
// combinationally from in_* to out_*.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_w      in   NUM_INPUTS*WORD_WIDTH packed words, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   sel       in   index of the word to forward
//   in_valid  in   in_w/sel valid this cycle
//   in_ready  out  block accepts the input this cycle
//   out_w     out  selected word (holds its last value when empty)
//   out_sel   out  select index that produced out_w
//   out_err   out  select index was >= NUM_INPUTS
//   out_valid out  out_* valid
//   out_ready in   consumer accepts out_* this cycle
module mux_n_to_1_pipe #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned SEL_WIDTH  = 3,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_INPUTS*WORD_WIDTH-1:0] in_w,
  input  logic [SEL_WIDTH-1:0]           sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WORD_WIDTH-1:0]          out_w,
  output logic [SEL_WIDTH-1:0]           out_sel,
  output logic                           out_err,
  output logic                           out_valid,
  input  logic                           out_ready
);

  // Input-side selection
  logic [WORD_WIDTH-1:0] mux_word;
  logic                  mux_err;

  // Scanning every legal index avoids a variable part-select that could run
  // past the end of in_w when sel is out of range.
  always_comb begin
    mux_word = '0;
    mux_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        mux_word = in_w[k*WORD_WIDTH +: WORD_WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  // Pipeline stage storage; index 0 is stage 1 (nearest the input)
  logic [PIPE_DEPTH-1:0] v_q;
  logic [PIPE_DEPTH-1:0] err_q;
  logic [WORD_WIDTH-1:0] word_q [PIPE_DEPTH];
  logic [SEL_WIDTH-1:0]  sel_q  [PIPE_DEPTH];

  // Backward ready chain: a stage loads when it is empty or drains this cycle
  logic [PIPE_DEPTH-1:0] ld;
  logic                  rdy_chain;

  always_comb begin
    ld        = '0;
    rdy_chain = out_ready;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      ld[i]     = ~v_q[i] | rdy_chain;
      rdy_chain = ld[i];
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      err_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        word_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      if (ld[0]) begin
        v_q[0] <= in_valid;
        // Payload only moves with a valid word, so an empty stage keeps its last value.
        if (in_valid) begin
          word_q[0] <= mux_word;
          sel_q[0]  <= sel;
          err_q[0]  <= mux_err;
        end
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (ld[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            word_q[i] <= word_q[i-1];
            sel_q[i]  <= sel_q[i-1];
            err_q[i]  <= err_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v_q[PIPE_DEPTH-1];
  assign out_w     = word_q[PIPE_DEPTH-1];
  assign out_sel   = sel_q[PIPE_DEPTH-1];
  assign out_err   = err_q[PIPE_DEPTH-1];

endmodule
